io_bus_master: RTL and testbench
================================

# io_bus_master

Initiator side of the 8-bit IO bus. It turns single-cycle read/write requests from the CPU control logic into a timed IO bus transaction: chip enable, address, strobe, bus drive and read-data capture. It drives the same NCE/NOE/NWE/address/data signals that IO peripherals (switch/LED port at address 0x00, and others) respond to. It sits between the control unit and the IO peripherals on the shared 8-bit data bus.

## Interface
Parameters:
- SETUP_CYCLES, 1, cycles address/NCE (and write data) are valid before the strobe; range 1..255
- STROBE_CYCLES, 2, cycles NOE or NWE is held low; range 1..255
- HOLD_CYCLES, 1, cycles address/NCE (and write data) stay valid after the strobe; range 1..255

Ports (one clock `i_clk`; reset `i_resetn` is synchronous and active-low):
- i_clk  in  1  clock; all state changes on rising edge
- i_resetn  in  1  synchronous active-low reset
- i_req  in  1  transaction request; sampled only in IDLE
- i_write  in  1  1 = write, 0 = read; sampled with i_req
- i_address  in  8  IO address; sampled with i_req
- i_wdata  in  8  write data; sampled with i_req
- o_busy  out  1  high while a transaction is in progress
- o_done  out  1  one-cycle pulse when a transaction completes
- o_rdata  out  8  last captured read data; held until the next read completes
- o_ioNCE  out  1  IO chip enable, active low
- o_ioAddress  out  8  IO address
- o_ioNOE  out  1  IO output enable (read strobe), active low
- o_ioNWE  out  1  IO write enable (write strobe), active low
- o_bus  out  8  data driven onto the shared bus during writes
- o_busNOE  out  1  bus drive enable, active low; low only during writes
- i_bus  in  8  shared bus data, read from the peripheral

## Operation
- FSM states and transitions:
  - IDLE → SETUP on i_req = 1. At that edge, latch address, write flag and wdata, and load the counter with SETUP_CYCLES-1.
  - SETUP → STROBE when the counter reaches 0.
  - STROBE → HOLD when the counter reaches 0.
  - HOLD → IDLE when the counter reaches 0.
  - The counter is 8 bits. It is reloaded with N-1 on entry to each state and decremented each cycle otherwise.
- All IO outputs are registers; no combinational decode onto the IO lines.
- Output values per state:
  - IDLE: o_ioNCE=1, o_ioNOE=1, o_ioNWE=1, o_busNOE=1. o_ioAddress and o_bus hold their last values.
  - SETUP: o_ioNCE=0 and o_ioAddress = latched address. On writes, o_busNOE=0 and o_bus = latched wdata.
  - STROBE: same as SETUP, plus o_ioNOE=0 on reads or o_ioNWE=0 on writes.
  - HOLD: same as SETUP; both strobes back high.
- o_busy = 1 in SETUP, STROBE and HOLD.
- Read capture: o_rdata <= i_bus at the edge that leaves STROBE. Writes never change o_rdata.
- o_done is high for exactly one cycle: the first IDLE cycle after HOLD.
- An i_req in that same cycle is accepted, giving back-to-back transactions.
- i_req while busy is ignored, not queued.
- Reset values: o_ioNCE=1, o_ioNOE=1, o_ioNWE=1, o_busNOE=1, o_ioAddress=0x00, o_bus=0x00, o_rdata=0x00, o_busy=0, o_done=0, state IDLE.
- Reset mid-transaction: at the next rising edge with i_resetn=0, the block returns to IDLE with all reset values.
  - No o_done pulse is produced.
  - o_rdata is not updated.
  - i_req is ignored while i_resetn=0.

## Timing
- Let S, W, H be the three parameters. i_req is sampled at edge 0.
- Cycles 1..S: SETUP.
- Cycles S+1..S+W: STROBE.
- Cycles S+W+1..S+W+H: HOLD.
- Cycle S+W+H+1: o_done=1 (IDLE). With defaults that is cycle 5.
- Minimum request-to-request interval is S+W+H+1 cycles.
- NCE, address and write data are stable for S cycles before and H cycles after every strobe. Strobes never change in the same cycle as NCE or address.
- Read data must be valid on i_bus by the end of the last STROBE cycle.
- A responder that samples on every rising edge with NWE low sees the same data W times. This is harmless.

## Test plan
- Write, defaults, i_address=0x00, i_wdata=0xA5:
  - o_ioNCE=0 and o_busNOE=0 with o_bus=0xA5 for cycles 1–4.
  - o_ioNWE=0 for cycles 2–3; o_ioNOE stays 1.
  - o_done in cycle 5.
  - Attached switch/LED responder output reads 0xA5.
- Read, defaults, responder switches=0x3C:
  - o_ioNOE=0 for cycles 2–3; o_busNOE stays 1.
  - o_rdata=0x3C with o_done in cycle 5.
  - A following write leaves o_rdata=0x3C.
- Back-to-back: write 0x11, then a read issued in the o_done cycle.
  - Second NCE-low window starts in cycle 6.
  - o_ioNCE returns high for exactly 1 cycle between the two transactions (cycle 5).
- i_req pulsed in cycles 2 and 3 of a write: ignored; exactly one o_done.
- i_resetn=0 during STROBE of a write:
  - Next edge: all strobes 1, o_busNOE=1, o_busy=0, o_done never asserted.
  - Responder output keeps only data already latched.
- Parameters S=3, W=1, H=2, read:
  - o_ioNOE low only in cycle 4.
  - o_ioNCE low in cycles 1–6.
  - o_done in cycle 7.

Source files
------------

// File: rtl/io_bus_master.sv
// io_bus_master: initiator side of the 8-bit IO bus.
// Turns a single-cycle CPU request into a timed NCE / address / strobe
// sequence with registered IO outputs, and captures read data from the
// shared bus at the end of the strobe window.
module io_bus_master #(
    parameter int unsigned SETUP_CYCLES  = 1,  // 1..255
    parameter int unsigned STROBE_CYCLES = 2,  // 1..255
    parameter int unsigned HOLD_CYCLES   = 1   // 1..255
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_req,
    input  logic       i_write,
    input  logic [7:0] i_address,
    input  logic [7:0] i_wdata,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_ioNCE,
    output logic [7:0] o_ioAddress,
    output logic       o_ioNOE,
    output logic       o_ioNWE,
    output logic [7:0] o_bus,
    output logic       o_busNOE,
    input  logic [7:0] i_bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    // Counter reload values: each phase lasts N cycles, counting N-1 down to 0.
    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       write_q, write_d;

    // Registered IO outputs. Their next values are derived from the next
    // state so every IO line changes exactly on the edge that enters a phase.
    logic       nce_q, nce_d;
    logic       noe_q, noe_d;
    logic       nwe_q, nwe_d;
    logic       busnoe_q, busnoe_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] bus_q, bus_d;
    logic [7:0] rdata_q, rdata_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Next-state, counter, latching and next-output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q - 8'd1;
        write_d  = write_q;
        addr_d   = addr_q;
        bus_d    = bus_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = cnt_q;
                if (i_req) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                    write_d = i_write;
                    addr_d  = i_address;
                    // o_bus only ever shows write data; reads leave it alone.
                    if (i_write) begin
                        bus_d = i_wdata;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LD;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                    // Peripheral data must be valid by the end of the last strobe cycle.
                    if (!write_q) begin
                        rdata_d = i_bus;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        busy_d   = (state_d != ST_IDLE);
        nce_d    = !busy_d;
        busnoe_d = !(busy_d && write_d);
        noe_d    = !((state_d == ST_STROBE) && !write_d);
        nwe_d    = !((state_d == ST_STROBE) && write_d);
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            write_q  <= 1'b0;
            nce_q    <= 1'b1;
            noe_q    <= 1'b1;
            nwe_q    <= 1'b1;
            busnoe_q <= 1'b1;
            addr_q   <= 8'h00;
            bus_q    <= 8'h00;
            rdata_q  <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            nce_q    <= nce_d;
            noe_q    <= noe_d;
            nwe_q    <= nwe_d;
            busnoe_q <= busnoe_d;
            addr_q   <= addr_d;
            bus_q    <= bus_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_rdata     = rdata_q;
    assign o_ioNCE     = nce_q;
    assign o_ioAddress = addr_q;
    assign o_ioNOE     = noe_q;
    assign o_ioNWE     = nwe_q;
    assign o_bus       = bus_q;
    assign o_busNOE    = busnoe_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: two instances (default timing and S=3/W=1/H=2)
// share one stimulus stream; a transaction-level model predicts every IO
// line each cycle, plus a switch/LED responder at address 0x00.
module tb_io_bus_master;

    localparam int unsigned SP[2] = '{1, 3};
    localparam int unsigned WP[2] = '{2, 1};
    localparam int unsigned HP[2] = '{1, 2};

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] sw = 8'h00;

    logic       busy[2], done[2], nce[2], noe[2], nwe[2], busnoe[2];
    logic [7:0] rdata[2], ioaddr[2], bus_o[2], bus_i[2];
    logic [7:0] led[2] = '{8'h00, 8'h00};

    int total = 0;
    int bad = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] periph(input logic [7:0] a, input logic [7:0] s);
        return (a == 8'h00) ? s : (a ^ 8'h5A);
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        io_bus_master #(
            .SETUP_CYCLES (SP[k]),
            .STROBE_CYCLES(WP[k]),
            .HOLD_CYCLES  (HP[k])
        ) u_dut (
            .i_clk      (clk),
            .i_resetn   (resetn),
            .i_req      (req),
            .i_write    (wr),
            .i_address  (addr),
            .i_wdata    (wdata),
            .o_busy     (busy[k]),
            .o_done     (done[k]),
            .o_rdata    (rdata[k]),
            .o_ioNCE    (nce[k]),
            .o_ioAddress(ioaddr[k]),
            .o_ioNOE    (noe[k]),
            .o_ioNWE    (nwe[k]),
            .o_bus      (bus_o[k]),
            .o_busNOE   (busnoe[k]),
            .i_bus      (bus_i[k])
        );

        // Shared bus: master drive wins, else the addressed peripheral on NOE, else pull-up.
        assign bus_i[k] = !busnoe[k] ? bus_o[k] :
                          (!nce[k] && !noe[k]) ? periph(ioaddr[k], sw) : 8'hFF;

        // Switch/LED responder: LED latch on every edge that sees a write strobe.
        always @(posedge clk) begin
            if (nce[k] === 1'b0 && nwe[k] === 1'b0 && ioaddr[k] == 8'h00)
                led[k] <= bus_o[k];
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: each transaction is a cycle index rel=1..S+W+H.
    bit         m_act[2];
    int         m_rel[2];
    bit         m_wr[2];
    bit         m_done[2];
    logic [7:0] m_addr[2], m_bus[2], m_wd[2], m_rd[2];
    logic [7:0] m_led[2] = '{8'h00, 8'h00};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int s, w, t;
            bit idle_before;
            s = int'(SP[k]);
            w = int'(WP[k]);
            t = int'(SP[k] + WP[k] + HP[k]);
            if (m_act[k] && m_rel[k] > s && m_rel[k] <= s + w && m_wr[k] && m_addr[k] == 8'h00)
                m_led[k] = m_wd[k];
            if (!resetn) begin
                m_act[k] = 0; m_rel[k] = 0; m_done[k] = 0; m_wr[k] = 0;
                m_addr[k] = 8'h00; m_bus[k] = 8'h00; m_rd[k] = 8'h00;
            end else begin
                if (m_act[k] && !m_wr[k] && m_rel[k] == s + w)
                    m_rd[k] = periph(m_addr[k], sw);
                idle_before = !m_act[k];
                m_done[k] = 0;
                if (m_act[k]) begin
                    if (m_rel[k] == t) begin
                        m_act[k] = 0;
                        m_done[k] = 1;
                    end else begin
                        m_rel[k]++;
                    end
                end
                if (idle_before && req) begin
                    m_act[k] = 1; m_rel[k] = 1; m_wr[k] = wr;
                    m_addr[k] = addr; m_wd[k] = wdata;
                    if (wr) m_bus[k] = wdata;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                bit strobe;
                strobe = m_act[k] && m_rel[k] > int'(SP[k]) && m_rel[k] <= int'(SP[k] + WP[k]);
                check($sformatf("nce%0d", k), 16'(nce[k]), 16'(!m_act[k]));
                check($sformatf("noe%0d", k), 16'(noe[k]), 16'(!(strobe && !m_wr[k])));
                check($sformatf("nwe%0d", k), 16'(nwe[k]), 16'(!(strobe && m_wr[k])));
                check($sformatf("busnoe%0d", k), 16'(busnoe[k]), 16'(!(m_act[k] && m_wr[k])));
                check($sformatf("busy%0d", k), 16'(busy[k]), 16'(m_act[k]));
                check($sformatf("done%0d", k), 16'(done[k]), 16'(m_done[k]));
                check($sformatf("addr%0d", k), 16'(ioaddr[k]), 16'(m_addr[k]));
                check($sformatf("bus%0d", k), 16'(bus_o[k]), 16'(m_bus[k]));
                check($sformatf("rdata%0d", k), 16'(rdata[k]), 16'(m_rd[k]));
                check($sformatf("led%0d", k), 16'(led[k]), 16'(m_led[k]));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
        req = 1'b1; wr = w; addr = a; wdata = d;
        next_cycle();
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    initial begin
        int dcnt;
        bit seen;
        resetn = 1'b0;
        next_cycle();
        chk_on = 1;
        idle(2);
        resetn = 1'b1;
        idle(2);

        // Write 0xA5 to the LED port.
        issue(1'b1, 8'h00, 8'hA5);
        idle(8);
        check("led_a5", 16'(led[0]), 16'h00A5);

        // Read switches 0x3C, then a write must not disturb o_rdata.
        sw = 8'h3C;
        issue(1'b0, 8'h00, 8'h00);
        idle(8);
        check("rd_3c", 16'(rdata[0]), 16'h003C);
        issue(1'b1, 8'h10, 8'h77);
        idle(8);
        check("rd_keep", 16'(rdata[0]), 16'h003C);

        // Back-to-back: read issued in the done cycle of the first instance.
        issue(1'b1, 8'h00, 8'h11);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done[0]) seen = 1;
            else next_cycle();
        end
        check("b2b_wait", 16'(seen), 16'd1);
        sw = 8'hC3;
        issue(1'b0, 8'h00, 8'h00);
        idle(10);
        check("b2b_rd", 16'(rdata[0]), 16'h00C3);

        // Requests during a busy write are dropped.
        dcnt = 0;
        issue(1'b1, 8'h20, 8'h42);             // cycle 0
        if (done[0]) dcnt++;
        next_cycle();                          // cycle 1
        req = 1'b1; wr = 1'b0; addr = 8'h30;   // cycles 2, 3
        for (int i = 0; i < 2; i++) begin
            if (done[0]) dcnt++;
            next_cycle();
        end
        req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done[0]) dcnt++;
            next_cycle();
        end
        check("one_done", 16'(dcnt), 16'd1);

        // Reset while the default instance is strobing a write.
        idle(2);
        issue(1'b1, 8'h00, 8'h5E);             // cycle 0
        next_cycle();                          // cycle 1
        resetn = 1'b0;                         // cycle 2 is STROBE; next edge resets
        next_cycle();
        check("rst_busy", 16'(busy[0]), 16'd0);
        check("rst_nwe", 16'(nwe[0]), 16'd1);
        resetn = 1'b1;
        idle(6);

        // Randomized traffic including occasional mid-transaction resets.
        for (int i = 0; i < 3000; i++) begin
            req    = ($urandom_range(0, 3) == 0);
            wr     = 1'($urandom);
            addr   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            wdata  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
            resetn = ($urandom_range(0, 79) != 0);
            next_cycle();
        end
        req = 1'b0;
        resetn = 1'b1;
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
